// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle plotter: FSM encodings, screen geometry and
// the 3-bit colour palette used by the sprite sequencer.
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int MAX_DIM  = 64;
  localparam int BG_COL   = 0;

  localparam logic [2:0] COL_BLACK   = 3'd0;
  localparam logic [2:0] COL_BLUE    = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_CYAN    = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;
  localparam logic [2:0] COL_YELLOW  = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

  function automatic int dim_bits(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row walker for a w x h rectangle; steps in raster order on each adv pulse
// and flags the bottom-right pixel through last.
module raster_counter #(
  parameter int DIM_W = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  input  logic             clr,
  input  logic             adv,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == w - DIM_W'(1));
  assign row_end = (row == h - DIM_W'(1));
  assign last    = col_end && row_end;

  // Row runs one past h-1 after the final advance; the FSM leaves DRAW then and LOAD clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/shape_draw_ctrl.sv
// Rectangle plotter: latches a shape on start, walks it pixel by pixel into the VGA
// write port, drops off-screen pixels and reports how many were written.
module shape_draw_ctrl
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int MAX_DIM  = draw_pkg::MAX_DIM,
  parameter int BG_COL   = draw_pkg::BG_COL,
  parameter int DIM_W    = draw_pkg::dim_bits(MAX_DIM)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x_origin,
  input  logic [Y_W-1:0]     y_origin,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  input  logic [C_W-1:0]     colour_in,
  input  logic               erase,
  input  logic               plot_ready,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               plot,
  output logic [2*DIM_W-1:0] pixel_count,
  output logic [1:0]         state_dbg
);

  localparam int PC_W = 2 * DIM_W;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [X_W:0]     X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]     Y_LIM = (Y_W + 1)'(SCREEN_H);
  localparam logic [C_W-1:0]   BG    = C_W'(BG_COL);

  state_t state, state_next;

  logic [X_W-1:0]   x_lat;
  logic [Y_W-1:0]   y_lat;
  logic [DIM_W-1:0] w_lat, h_lat;
  logic [C_W-1:0]   colour_lat;
  logic             erase_lat;
  logic [DIM_W-1:0] col, row;
  logic             last, clr, adv, accept, clipped;
  logic [X_W:0]     x_full;
  logic [Y_W:0]     y_full;

  // Handshake: a pixel write completes in any DRAW cycle where plot and plot_ready are
  // both high; with plot_ready low the address, colour and strobe are held unchanged.
  assign accept  = (state == ST_IDLE) && start;
  assign x_full  = {1'b0, x_lat} + (X_W + 1)'(col);
  assign y_full  = {1'b0, y_lat} + (Y_W + 1)'(row);
  assign clipped = (x_full >= X_LIM) || (y_full >= Y_LIM);
  assign clr     = (state == ST_LOAD);
  assign adv     = (state == ST_DRAW) && (clipped || plot_ready);
  assign state_dbg = state;

  raster_counter #(.DIM_W(DIM_W)) u_raster (
    .clock  (clock),
    .resetn (resetn),
    .w      (w_lat),
    .h      (h_lat),
    .clr    (clr),
    .adv    (adv),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = (w_lat == '0 || h_lat == '0) ? ST_DONE : ST_DRAW;
      ST_DRAW: if (adv && last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    plot       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    case (state)
      ST_LOAD: busy = 1'b1;
      ST_DRAW: begin
        busy       = 1'b1;
        plot       = !clipped;
        vga_x      = x_full[X_W-1:0];
        vga_y      = y_full[Y_W-1:0];
        vga_colour = erase_lat ? BG : colour_lat;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_lat       <= '0;
      y_lat       <= '0;
      w_lat       <= '0;
      h_lat       <= '0;
      colour_lat  <= '0;
      erase_lat   <= 1'b0;
      pixel_count <= '0;
    end else if (accept) begin
      x_lat       <= x_origin;
      y_lat       <= y_origin;
      w_lat       <= (width  > MAX_D) ? MAX_D : width;
      h_lat       <= (height > MAX_D) ? MAX_D : height;
      colour_lat  <= colour_in;
      erase_lat   <= erase;
      pixel_count <= '0;
    end else if (state == ST_DRAW && !clipped && plot_ready) begin
      pixel_count <= pixel_count + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_shape_draw_ctrl.sv
// Bench for shape_draw_ctrl: reference raster model feeds an expected-pixel queue that is
// drained as the DUT's accepted writes appear.
module tb_shape_draw_ctrl;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int DIM_W = 7;
  localparam int PC_W  = 2 * DIM_W;
  localparam int E_W   = X_W + Y_W + C_W;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [X_W-1:0]   x_origin = '0;
  logic [Y_W-1:0]   y_origin = '0;
  logic [DIM_W-1:0] width = '0;
  logic [DIM_W-1:0] height = '0;
  logic [C_W-1:0]   colour_in = '0;
  logic             erase = 1'b0;
  logic             plot_ready = 1'b1;
  logic             busy, done, plot;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic [PC_W-1:0]  pixel_count;
  logic [1:0]       state_dbg;

  logic [E_W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  shape_draw_ctrl dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .x_origin    (x_origin),
    .y_origin    (y_origin),
    .width       (width),
    .height      (height),
    .colour_in   (colour_in),
    .erase       (erase),
    .plot_ready  (plot_ready),
    .busy        (busy),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .plot        (plot),
    .pixel_count (pixel_count),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  // Reference model: every on-screen pixel of the shape in raster order.
  task automatic push_shape(input int x, input int y, input int w, input int h,
                            input int c, input bit e);
    int ws, hs, px, py, cc;
    ws = (w > 64) ? 64 : w;
    hs = (h > 64) ? 64 : h;
    cc = e ? 0 : c;
    for (int r = 0; r < hs; r++) begin
      for (int k = 0; k < ws; k++) begin
        px = x + k;
        py = y + r;
        if (px < 160 && py < 120)
          exp_q.push_back({X_W'(px), Y_W'(py), C_W'(cc)});
      end
    end
  endtask

  task automatic drive_start(input int x, input int y, input int w, input int h,
                             input int c, input bit e);
    @(negedge clock);
    x_origin  = X_W'(x);
    y_origin  = Y_W'(y);
    width     = DIM_W'(w);
    height    = DIM_W'(h);
    colour_in = C_W'(c);
    erase     = e;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Cycle k counts from the accepted start edge; returns at the DONE cycle or after an abort.
  task automatic collect(input int exp_done, input int exp_count, input bit toggle,
                         input int inject_cycle, input int abort_after);
    int acc = 0;
    bit seen_done = 1'b0;
    bit held = 1'b0;
    bit bad_busy = 1'b0;
    bit bad_done = 1'b0;
    logic [E_W:0] hold_v;
    logic [E_W-1:0] got, want;
    for (int k = 1; k <= exp_done + 20 && !seen_done; k++) begin
      if (toggle) plot_ready = k[0];
      if (k == inject_cycle) begin
        start    = 1'b1;
        x_origin = x_origin + X_W'(7);
        y_origin = y_origin + Y_W'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (held) begin
        checks++;
        if ({plot, vga_x, vga_y, vga_colour} !== hold_v)
          $display("FAIL stall_hold: got %0h expected %0h", {plot, vga_x, vga_y, vga_colour}, hold_v);
        else passed++;
      end
      held   = plot && !plot_ready;
      hold_v = {plot, vga_x, vga_y, vga_colour};
      if (plot && plot_ready) begin
        acc++;
        got = {vga_x, vga_y, vga_colour};
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_plot: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) $display("FAIL plot_data: got %0h expected %0h", got, want);
          else passed++;
        end
        if (abort_after > 0 && acc == abort_after) begin
          resetn = 1'b0;
          #1;
          checks++;
          if ({busy, done, plot, vga_x, vga_y, vga_colour, pixel_count, state_dbg} !== '0)
            $display("FAIL reset_outputs: got %0h expected 0",
                     {busy, done, plot, vga_x, vga_y, vga_colour, pixel_count, state_dbg});
          else passed++;
          for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== 1'b0) bad_done = 1'b1;
          end
          resetn = 1'b1;
          for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done !== 1'b0) bad_done = 1'b1;
          end
          checks++;
          if (bad_done) $display("FAIL no_done_after_reset: got 1 expected 0");
          else passed++;
          exp_q.delete();
          return;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (k != exp_done) $display("FAIL done_cycle: got %0d expected %0d", k, exp_done);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_in_done: got %b expected 0", busy);
        else passed++;
      end else if (busy !== 1'b1) begin
        bad_busy = 1'b1;
      end
      if (!seen_done) begin
        @(posedge clock);
        #1;
      end
    end
    start      = 1'b0;
    plot_ready = 1'b1;
    checks++;
    if (!seen_done) $display("FAIL done_timeout: got none expected cycle %0d", exp_done);
    else passed++;
    checks++;
    if (bad_busy) $display("FAIL busy_high: got 0 expected 1 before done");
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d left expected 0", exp_q.size());
    else passed++;
    checks++;
    if (pixel_count !== PC_W'(exp_count))
      $display("FAIL pixel_count: got %0d expected %0d", pixel_count, exp_count);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({busy, done, plot, vga_x, vga_y, vga_colour, pixel_count, state_dbg} !== '0)
      $display("FAIL reset_state: got %0h expected 0",
               {busy, done, plot, vga_x, vga_y, vga_colour, pixel_count, state_dbg});
    else passed++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    push_shape(10, 20, 3, 2, 5, 1'b0);
    drive_start(10, 20, 3, 2, 5, 1'b0);
    collect(8, 6, 1'b0, 0, 0);
  endtask

  task automatic test_clip();
    push_shape(158, 118, 4, 4, 2, 1'b0);
    drive_start(158, 118, 4, 4, 2, 1'b0);
    collect(18, 4, 1'b0, 0, 0);
  endtask

  task automatic test_stall();
    push_shape(30, 40, 2, 2, 3, 1'b0);
    drive_start(30, 40, 2, 2, 3, 1'b0);
    collect(10, 4, 1'b1, 0, 0);
  endtask

  task automatic test_zero_size();
    drive_start(5, 5, 0, 5, 1, 1'b0);
    collect(2, 0, 1'b0, 0, 0);
  endtask

  task automatic test_erase_ignore_start();
    push_shape(50, 60, 5, 3, 7, 1'b1);
    drive_start(50, 60, 5, 3, 7, 1'b1);
    colour_in = 3'd2;
    erase     = 1'b0;
    collect(17, 15, 1'b0, 4, 0);
  endtask

  task automatic test_saturate();
    push_shape(100, 50, 100, 2, 6, 1'b0);
    drive_start(100, 50, 100, 2, 6, 1'b0);
    collect(130, 120, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int x, y, w, h, c, n;
    for (int i = 0; i < 4; i++) begin
      x = $urandom_range(0, 200);
      y = $urandom_range(0, 127);
      w = $urandom_range(0, 8);
      h = $urandom_range(1, 8);
      c = $urandom_range(0, 7);
      push_shape(x, y, w, h, c, 1'b0);
      n = exp_q.size();
      drive_start(x, y, w, h, c, 1'b0);
      collect(2 + w * h, n, 1'b0, 0, 0);
    end
  endtask

  task automatic test_abort_and_full();
    push_shape(0, 0, 60, 60, 4, 1'b0);
    drive_start(0, 0, 60, 60, 4, 1'b0);
    collect(3602, 0, 1'b0, 0, 3);
    push_shape(0, 0, 60, 60, 4, 1'b0);
    drive_start(0, 0, 60, 60, 4, 1'b0);
    collect(3602, 3600, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_zero_size();
    test_erase_ignore_start();
    test_saturate();
    test_back_to_back();
    test_abort_and_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
